multicycle_alu: RTL and testbench

Parametrised, handshaked successor to the datapath's combinational ALU. Accepts one operation per transaction over a valid/ready input interface, computes it in a registered stage, and holds the result on a valid/ready output interface until consumed. Adds XOR, shifts, set-less-than and an optional iterative multiplier. It sits between operand fetch (register file plus immediate generator) and the writeback/branch logic of the processor core.

---
 rtl/multicycle_alu.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with a registered result stage.
// Non-MUL operations complete one cycle after they are accepted. MUL is a
// shift-add multiplier that retires one multiplier bit per cycle. It is built
// only when MULTICYCLE_ALU_MUL_EN is defined. Otherwise opcode 11 is illegal.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             use_reg,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2_reg,
    input  logic [WIDTH-1:0] operand2_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd5;
    localparam logic [3:0] OP_BEQ = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;

`ifdef MULTICYCLE_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam int         CNT_W  = SHAMT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    typedef struct packed {
        logic             ill;
        logic             zero;
        logic [WIDTH-1:0] res;
    } alu_out_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] opb;
    alu_out_t         alu_d;

    // Single-cycle operations. The BEQ difference is also returned as the result.
    function automatic alu_out_t alu_eval(input logic [3:0]       f_op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        alu_out_t                o;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic        [WIDTH-1:0] diff;
        o    = '0;
        sa   = a;
        sb   = b;
        diff = a - b;
        case (f_op)
            OP_ADD, OP_LW, OP_SW: o.res = a + b;
            OP_SUB:               o.res = diff;
            OP_AND:               o.res = a & b;
            OP_OR:                o.res = a | b;
            OP_XOR:               o.res = a ^ b;
            OP_BEQ: begin
                o.res  = diff;
                o.zero = (diff == '0);
            end
            OP_SLL:               o.res = a << b[SHAMT_W-1:0];
            OP_SRL:               o.res = a >> b[SHAMT_W-1:0];
            OP_SLT:               o.res = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            default:              o.ill = 1'b1;
        endcase
        return o;
    endfunction

    // LW/SW always address with the immediate, whatever use_reg says.
    assign opb      = (op == OP_LW || op == OP_SW) ? operand2_imm
                    : (use_reg ? operand2_reg : operand2_imm);
    assign alu_d    = alu_eval(op, operand1, opb);
    assign in_ready = (state_q == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

`ifdef MULTICYCLE_ALU_MUL_EN
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_next;
    logic             mul_last;

    assign is_mul   = (op == OP_MUL);
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last = (state_q == S_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));

    // Iteration counter. It restarts on every accept and advances once per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Shift-add datapath. The multiplier is consumed LSB first while the multiplicand walks left.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q    <= '0;
            mcand_q  <= operand1;
            mplier_q <= opb;
        end else if (state_q == S_BUSY) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. Illegal opcodes go straight to DONE like any single-cycle op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MULTICYCLE_ALU_MUL_EN
                    state_d = is_mul ? S_BUSY : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            S_BUSY: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // out_valid is a registered copy of "in DONE". It drops only on the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == S_DONE);
        end
    end

    // Result stage. It loads on a single-cycle accept or on the last multiply iteration, and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            zero_flag <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !is_mul) begin
            result    <= alu_d.res;
            zero_flag <= alu_d.zero;
            illegal   <= alu_d.ill;
        end
`ifdef MULTICYCLE_ALU_MUL_EN
        else if (mul_last) begin
            result    <= acc_next;
            zero_flag <= 1'b0;
            illegal   <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu. A driver pushes expected responses into a
// scoreboard queue, and a monitor pops and compares them on each output handshake.
module tb_multicycle_alu;

    localparam int W = 32;
`ifdef MULTICYCLE_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
        int           lat;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic         use_reg = 1'b0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2_reg = '0;
    logic [W-1:0] operand2_imm = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero_flag;
    logic         illegal;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    exp_t scb[$];

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .use_reg(use_reg), .operand1(operand1),
        .operand2_reg(operand2_reg), .operand2_imm(operand2_imm),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero_flag(zero_flag), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, random, or stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Reference model computed directly from the opcode table.
    function automatic exp_t model(input logic [3:0] f_op, input logic f_use,
                                   input logic [W-1:0] a, input logic [W-1:0] r,
                                   input logic [W-1:0] imm);
        exp_t         e;
        logic [W-1:0] b;
        logic [63:0]  prod;
        b      = (f_op == 4'd4 || f_op == 4'd5) ? imm : (f_use ? r : imm);
        e.res  = '0;
        e.zero = 1'b0;
        e.ill  = 1'b0;
        e.lat  = 1;
        e.acc_cyc = 0;
        case (f_op)
            4'd0, 4'd4, 4'd5: e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd6: begin
                e.res  = a - b;
                e.zero = (a == b);
            end
            4'd7:  e.res = a ^ b;
            4'd8:  e.res = a << (b % W);
            4'd9:  e.res = a >> (b % W);
            4'd10: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: begin
                if (MUL_EN) begin
                    prod  = 64'(a) * 64'(b);
                    e.res = prod[W-1:0];
                    e.lat = W + 1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [3:0] f_op, input logic f_use, input logic [W-1:0] a,
                         input logic [W-1:0] r, input logic [W-1:0] imm);
        int   w;
        exp_t e;
        @(negedge clk);
        op = f_op; use_reg = f_use; operand1 = a; operand2_reg = r; operand2_imm = imm;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout got in_ready=%b want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        e = model(f_op, f_use, a, r, imm);
        e.acc_cyc = cyc;
        scb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); use_reg = 1'($urandom);
        operand1 = $urandom; operand2_reg = $urandom; operand2_imm = $urandom;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL valid_timeout got out_valid=%b want 1", out_valid);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (scb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(scb.size()), 32'd0);
    endtask

    // Monitor: latency on the first valid cycle, hold-stability while stalled, payload on the handshake.
    logic         have_first = 1'b0;
    logic [W-1:0] first_res;
    logic         first_zero;
    logic         first_ill;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_first = 1'b0;
        end else if (out_valid) begin
            if (scb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_out got out_valid=1 result=%h want no output", result);
            end else begin
                if (!have_first) begin
                    have_first = 1'b1;
                    first_res = result; first_zero = zero_flag; first_ill = illegal;
                    check("latency", 32'(cyc - scb[0].acc_cyc), 32'(scb[0].lat));
                end else begin
                    check("hold_stable", {result[W-3:0], zero_flag, illegal},
                          {first_res[W-3:0], first_zero, first_ill});
                end
                check("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
                if (out_ready) begin
                    e = scb.pop_front();
                    have_first = 1'b0;
                    check("result", result, e.res);
                    check("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
                    check("illegal", {31'd0, illegal}, {31'd0, e.ill});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, zero_flag, illegal}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Directed operations
        issue(4'd0, 1'b1, 32'd5, 32'd7, 32'd99);
        issue(4'd6, 1'b1, 32'h1234, 32'h1234, 32'd0);
        issue(4'd1, 1'b1, 32'd0, 32'd1, 32'd5);
        issue(4'd5, 1'b1, 32'h100, 32'hDEAD, 32'h8);
        issue(4'd4, 1'b1, 32'h200, 32'hBEEF, 32'h10);
        issue(4'd10, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0);
        issue(4'd9, 1'b1, 32'h80000000, 32'd31, 32'd0);
        issue(4'd8, 1'b0, 32'h00000003, 32'd0, 32'd36);
        issue(4'd7, 1'b0, 32'hF0F0F0F0, 32'd0, 32'hFF00FF00);
        issue(4'd13, 1'b1, 32'd1, 32'd2, 32'd3);
        drain();

        // Multiply: in_ready stays low until the result appears
        issue(4'd11, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            check("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        drain();

        // Backpressure: the result is held and the next op waits for the drain
        rdy_mode = 2;
        issue(4'd3, 1'b1, 32'h0F, 32'hF0, 32'd0);
        wait_valid();
        fork
            issue(4'd2, 1'b1, 32'hFF, 32'h3C, 32'd0);
            begin
                repeat (10) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Randomized traffic with a random consumer
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] b2;
            b2 = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(4'($urandom_range(0, 15)), 1'($urandom), $urandom, b2, $urandom);
        end
        rdy_mode = 0;
        drain();

        // Reset in the middle of a multiply aborts it
        issue(4'd11, 1'b1, 32'h1234, 32'h5678, 32'd0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        scb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_abort", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            check("no_valid_after_abort", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        // The block is usable again after the abort
        issue(4'd0, 1'b0, 32'd100, 32'd0, 32'd23);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
